// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : program_sequencer
// Purpose  : Program counter for the 8-bit CPU family. It supports increment
//            with wrap-around, jump, conditional branch, call/return through
//            an internal return-address stack, and halt/resume.
// Revision : 1.0  - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   ADDR_W      - width of pc, target and stack entries (min 2)
//   STACK_DEPTH - number of return-address stack entries (min 1)
//   RESET_VEC   - pc value loaded on reset
// Ports:
//   clk            - system clock, rising edge
//   reset          - synchronous, active-high reset
//   pc_enable_i    - advance enable; 0 holds all state
//   op_i[2:0]      - 0 INC, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5 HALT, 6/7 INC
//   target_i       - destination for JUMP / BRANCH / CALL
//   cond_i         - branch condition (BRANCH only)
//   resume_i       - leave the HALTED state
//   pc_o           - current program counter
//   halted_o       - high while HALTED
//   stack_level_o  - number of valid stack entries
//   stack_ovf_o    - sticky: CALL issued with the stack full
//   stack_unf_o    - sticky: RET issued with the stack empty
// Build option:
//   PC_FAULT_HALT_EN - when defined, a stack overflow/underflow also halts.
// ============================================================================
module program_sequencer #(
  parameter int                  ADDR_W      = 8,
  parameter int                  STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0]   RESET_VEC   = '0,
  localparam int                 LVL_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_enable_i,
  input  logic [2:0]        op_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              cond_i,
  input  logic              resume_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              halted_o,
  output logic [LVL_W-1:0]  stack_level_o,
  output logic              stack_ovf_o,
  output logic              stack_unf_o
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [2:0] OP_INC    = 3'd0;
  localparam logic [2:0] OP_JUMP   = 3'd1;
  localparam logic [2:0] OP_BRANCH = 3'd2;
  localparam logic [2:0] OP_CALL   = 3'd3;
  localparam logic [2:0] OP_RET    = 3'd4;
  localparam logic [2:0] OP_HALT   = 3'd5;

`ifdef PC_FAULT_HALT_EN
  localparam bit C_FAULT_HALT = 1'b1;
`else
  localparam bit C_FAULT_HALT = 1'b0;
`endif

  localparam logic [LVL_W-1:0] C_LVL_FULL = LVL_W'(STACK_DEPTH);
  localparam logic [LVL_W-1:0] C_LVL_ONE  = LVL_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [ADDR_W-1:0]   stack_q [STACK_DEPTH];

  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   stack_top;
  logic                push;

  // Natural-width addition wraps all-ones back to zero.
  assign pc_inc = pc_q + ADDR_W'(1);

  // Top of stack is the entry just below the current level.
  always_comb begin
    stack_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (level_q == LVL_W'(i + 1)) begin
        stack_top = stack_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;

    if (state_q == ST_HALTED) begin
      // The op presented alongside resume is deliberately dropped.
      if (resume_i) begin
        state_d = ST_RUN;
      end
    end else if (pc_enable_i) begin
      case (op_i)
        OP_JUMP: begin
          pc_d = target_i;
        end
        OP_BRANCH: begin
          pc_d = cond_i ? target_i : pc_inc;
        end
        OP_CALL: begin
          if (level_q == C_LVL_FULL) begin
            pc_d  = pc_inc;
            ovf_d = 1'b1;
            if (C_FAULT_HALT) begin
              state_d = ST_HALTED;
            end
          end else begin
            push    = 1'b1;
            pc_d    = target_i;
            level_d = level_q + C_LVL_ONE;
          end
        end
        OP_RET: begin
          if (level_q == '0) begin
            pc_d  = pc_inc;
            unf_d = 1'b1;
            if (C_FAULT_HALT) begin
              state_d = ST_HALTED;
            end
          end else begin
            pc_d    = stack_top;
            level_d = level_q - C_LVL_ONE;
          end
        end
        OP_HALT: begin
          state_d = ST_HALTED;
        end
        OP_INC: begin
          pc_d = pc_inc;
        end
        default: begin
          pc_d = pc_inc;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VEC;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage has no reset; validity is tracked by level_q alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (push && (level_q == LVL_W'(i))) begin
        stack_q[i] <= pc_inc;
      end
    end
  end

  assign pc_o          = pc_q;
  assign halted_o      = (state_q == ST_HALTED);
  assign stack_level_o = level_q;
  assign stack_ovf_o   = ovf_q;
  assign stack_unf_o   = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_sequencer
// Purpose  : Directed, table-driven self-checking bench for program_sequencer
//            with default parameters (ADDR_W=8, STACK_DEPTH=4, RESET_VEC=0).
// Revision : 1.0  - initial release
// ============================================================================
module tb_program_sequencer;

  localparam logic [2:0] INC = 3'd0, JMP = 3'd1, BR = 3'd2, CALL = 3'd3,
                         RET = 3'd4, HLT = 3'd5;

`ifdef PC_FAULT_HALT_EN
  localparam logic FH = 1'b1;
`else
  localparam logic FH = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       pc_enable_i;
  logic [2:0] op_i;
  logic [7:0] target_i;
  logic       cond_i;
  logic       resume_i;
  logic [7:0] pc_o;
  logic       halted_o;
  logic [2:0] stack_level_o;
  logic       stack_ovf_o;
  logic       stack_unf_o;

  program_sequencer #(
    .ADDR_W      (8),
    .STACK_DEPTH (4),
    .RESET_VEC   (8'h00)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_enable_i   (pc_enable_i),
    .op_i          (op_i),
    .target_i      (target_i),
    .cond_i        (cond_i),
    .resume_i      (resume_i),
    .pc_o          (pc_o),
    .halted_o      (halted_o),
    .stack_level_o (stack_level_o),
    .stack_ovf_o   (stack_ovf_o),
    .stack_unf_o   (stack_unf_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] op;
    logic [7:0] tgt;
    logic       cnd;
    logic       res;
    logic [7:0] pc;
    logic       h;
    logic [2:0] lvl;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic rst, input logic en, input logic [2:0] op,
                     input logic [7:0] tgt, input logic cnd, input logic res,
                     input logic [7:0] pc, input logic h, input logic [2:0] lvl,
                     input logic ovf, input logic unf);
    vec_t v;
    v.rst = rst; v.en = en; v.op = op; v.tgt = tgt; v.cnd = cnd; v.res = res;
    v.pc = pc; v.h = h; v.lvl = lvl; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic en, input logic [2:0] op,
                       input logic [7:0] tgt, input logic cnd, input logic res);
    reset = rst; pc_enable_i = en; op_i = op; target_i = tgt;
    cond_i = cnd; resume_i = res;
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] pc, input logic h,
                       input logic [2:0] lvl, input logic ovf, input logic unf);
    n_checks++;
    if (pc_o !== pc || halted_o !== h || stack_level_o !== lvl ||
        stack_ovf_o !== ovf || stack_unf_o !== unf) begin
      n_fail++;
      $display("FAIL %s: got pc=%h halted=%b level=%0d ovf=%b unf=%b, expected pc=%h halted=%b level=%0d ovf=%b unf=%b",
               name, pc_o, halted_o, stack_level_o, stack_ovf_o, stack_unf_o,
               pc, h, lvl, ovf, unf);
    end
  endtask

  initial begin
    drive(1, 0, INC, 8'h00, 0, 0);

    //   rst en op    tgt    c  r   pc     h   lvl ovf unf
    add(1, 0, INC,  8'h00, 0, 0,  8'h00, 0,  0,  0,  0);
    add(1, 0, INC,  8'h00, 0, 0,  8'h00, 0,  0,  0,  0);
    add(0, 1, INC,  8'h00, 0, 0,  8'h01, 0,  0,  0,  0);
    add(0, 1, INC,  8'h00, 0, 0,  8'h02, 0,  0,  0,  0);
    add(0, 1, INC,  8'h00, 0, 0,  8'h03, 0,  0,  0,  0);
    add(0, 1, INC,  8'h00, 0, 0,  8'h04, 0,  0,  0,  0);
    add(0, 1, INC,  8'h00, 0, 0,  8'h05, 0,  0,  0,  0);
    add(0, 1, 3'd6, 8'hAA, 1, 0,  8'h06, 0,  0,  0,  0);
    add(0, 1, 3'd7, 8'hAA, 1, 0,  8'h07, 0,  0,  0,  0);
    // hold / jump / branch
    add(0, 1, JMP,  8'h10, 0, 0,  8'h10, 0,  0,  0,  0);
    add(0, 0, JMP,  8'h99, 0, 0,  8'h10, 0,  0,  0,  0);
    add(0, 0, CALL, 8'h99, 0, 0,  8'h10, 0,  0,  0,  0);
    add(0, 0, HLT,  8'h99, 0, 0,  8'h10, 0,  0,  0,  0);
    add(0, 1, JMP,  8'h40, 0, 0,  8'h40, 0,  0,  0,  0);
    add(0, 1, BR,   8'h80, 0, 0,  8'h41, 0,  0,  0,  0);
    add(0, 1, BR,   8'h80, 1, 0,  8'h80, 0,  0,  0,  0);
    // wrap of all-ones
    add(0, 1, JMP,  8'hFF, 0, 0,  8'hFF, 0,  0,  0,  0);
    add(0, 1, INC,  8'h00, 0, 0,  8'h00, 0,  0,  0,  0);
    // nested call / return
    add(0, 1, JMP,  8'h05, 0, 0,  8'h05, 0,  0,  0,  0);
    add(0, 1, CALL, 8'h20, 0, 0,  8'h20, 0,  1,  0,  0);
    add(0, 1, CALL, 8'h30, 0, 0,  8'h30, 0,  2,  0,  0);
    add(0, 1, RET,  8'h77, 0, 0,  8'h21, 0,  1,  0,  0);
    add(0, 1, RET,  8'h77, 0, 0,  8'h06, 0,  0,  0,  0);
    // resume while running has no effect
    add(0, 1, INC,  8'h00, 0, 1,  8'h07, 0,  0,  0,  0);
    // stack full: fifth CALL behaves as INC
    add(0, 1, CALL, 8'h50, 0, 0,  8'h50, 0,  1,  0,  0);
    add(0, 1, CALL, 8'h60, 0, 0,  8'h60, 0,  2,  0,  0);
    add(0, 1, CALL, 8'h70, 0, 0,  8'h70, 0,  3,  0,  0);
    add(0, 1, CALL, 8'h80, 0, 0,  8'h80, 0,  4,  0,  0);
    add(0, 1, CALL, 8'h90, 0, 0,  8'h81, FH, 4,  1,  0);
    add(0, 0, INC,  8'h00, 0, 1,  8'h81, 0,  4,  1,  0);
    // drain, then underflow on the fifth RET
    add(0, 1, RET,  8'h00, 0, 0,  8'h71, 0,  3,  1,  0);
    add(0, 1, RET,  8'h00, 0, 0,  8'h61, 0,  2,  1,  0);
    add(0, 1, RET,  8'h00, 0, 0,  8'h51, 0,  1,  1,  0);
    add(0, 1, RET,  8'h00, 0, 0,  8'h08, 0,  0,  1,  0);
    add(0, 1, RET,  8'h00, 0, 0,  8'h09, FH, 0,  1,  1);
    add(0, 0, INC,  8'h00, 0, 1,  8'h09, 0,  0,  1,  1);
    add(0, 1, INC,  8'h00, 0, 0,  8'h0A, 0,  0,  1,  1);
    // halt / resume
    add(0, 1, JMP,  8'h12, 0, 0,  8'h12, 0,  0,  1,  1);
    add(0, 1, HLT,  8'h00, 0, 0,  8'h12, 1,  0,  1,  1);
    add(0, 1, JMP,  8'h99, 0, 0,  8'h12, 1,  0,  1,  1);
    add(0, 1, CALL, 8'h99, 0, 0,  8'h12, 1,  0,  1,  1);
    add(0, 1, RET,  8'h99, 0, 0,  8'h12, 1,  0,  1,  1);
    add(0, 1, JMP,  8'h99, 0, 0,  8'h12, 1,  0,  1,  1);
    add(0, 1, JMP,  8'h50, 0, 1,  8'h12, 0,  0,  1,  1);
    add(0, 1, INC,  8'h00, 0, 0,  8'h13, 0,  0,  1,  1);
    // reset from HALTED with three stacked entries
    add(0, 1, CALL, 8'h20, 0, 0,  8'h20, 0,  1,  1,  1);
    add(0, 1, CALL, 8'h30, 0, 0,  8'h30, 0,  2,  1,  1);
    add(0, 1, CALL, 8'h40, 0, 0,  8'h40, 0,  3,  1,  1);
    add(0, 1, HLT,  8'h00, 0, 0,  8'h40, 1,  3,  1,  1);
    add(1, 1, JMP,  8'h77, 0, 1,  8'h00, 0,  0,  0,  0);
    // RET on empty stack right after reset
    add(0, 1, RET,  8'h00, 0, 0,  8'h01, FH, 0,  0,  1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].op, vecs[i].tgt, vecs[i].cnd, vecs[i].res);
      step();
      check($sformatf("row%0d", i), vecs[i].pc, vecs[i].h, vecs[i].lvl,
            vecs[i].ovf, vecs[i].unf);
    end

    // Address pushed by CALL at all-ones wraps to 0x00.
    drive(1, 0, INC, 8'h00, 0, 0); step();
    drive(0, 1, JMP, 8'hFF, 0, 0); step();
    check("wrap_jump", 8'hFF, 0, 0, 0, 0);
    drive(0, 1, CALL, 8'h10, 0, 0); step();
    check("wrap_call", 8'h10, 0, 1, 0, 0);
    drive(0, 1, RET, 8'h00, 0, 0); step();
    check("wrap_ret", 8'h00, 0, 0, 0, 0);

    // Reset wins over a CALL presented in the same cycle.
    drive(0, 1, CALL, 8'h33, 0, 0); step();
    check("pre_rst_call", 8'h33, 0, 1, 0, 0);
    drive(1, 1, CALL, 8'h44, 0, 0); step();
    check("rst_vs_call", 8'h00, 0, 0, 0, 0);

    // Disabled RET must not pop; enabled RET then returns to the pushed value.
    drive(0, 1, JMP, 8'h7E, 0, 0); step();
    drive(0, 1, CALL, 8'h55, 0, 0); step();
    drive(0, 0, RET, 8'h00, 0, 0); step();
    check("hold_ret", 8'h55, 0, 1, 0, 0);
    drive(0, 1, RET, 8'h00, 0, 0); step();
    check("ret_after_hold", 8'h7F, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
